// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one op in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 strict priority instead of round-robin.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]    rsp0_result_q, rsp0_result_d;
    logic [WIDTH-1:0]    rsp1_result_q, rsp1_result_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic                grant0, grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                last_grant_q, last_grant_d;
`endif

    // Grant is the arbitration winner among current valids; it only matters while IDLE.
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
`endif
    end

    assign req0_ready = (state_q == IDLE) & grant0 & ~rst;
    assign req1_ready = (state_q == IDLE) & grant1 & ~rst;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    alu_a_d    = req0_a;
                    alu_b_d    = req0_b;
                    alu_ctrl_d = req0_ctrl;
                    owner_d    = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = 1'b0;
`endif
                    state_d    = EXEC;
                end else if (grant1) begin
                    alu_a_d    = req1_a;
                    alu_b_d    = req1_b;
                    alu_ctrl_d = req1_ctrl;
                    owner_d    = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = 1'b1;
`endif
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rsp1_result_d = alu_result;
                    rsp1_valid_d  = 1'b1;
                end else begin
                    rsp0_result_d = alu_result;
                    rsp0_valid_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (!owner_q && rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (owner_q && rsp1_ready) begin
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= '0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed cases then random ops, checked against a transaction-level model.
// Build with ALU_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_a, req0_b, rsp0_result;
    logic [2:0]  req0_ctrl;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_a, req1_b, rsp1_result;
    logic [2:0]  req1_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        busy;

    int checks = 0;
    int passed = 0;
    bit lastWinner = 1'b1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .busy(busy)
    );

    // Stand-in for the shared ALU: decodes only the low two control bits.
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl[1:0])
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            2'b11: alu_result = alu_a | alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        if (c[1:0] == 2'd0) return a + b;
        if (c[1:0] == 2'd1) return a - b;
        if (c[1:0] == 2'd2) return a & b;
        return a | b;
    endfunction

    function automatic int expectedWinner(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (lastWinner == 1'b0) ? 1 : 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    endtask

    task automatic checkResetState();
        checkOutput("rst_rsp0_valid", rsp0_valid, 0);
        checkOutput("rst_rsp1_valid", rsp1_valid, 0);
        checkOutput("rst_rsp0_result", rsp0_result, 0);
        checkOutput("rst_rsp1_result", rsp1_result, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req0_ready", req0_ready, 0);
        checkOutput("rst_req1_ready", req1_ready, 0);
    endtask

    // One complete transaction, entered #1 after a clock edge with the DUT idle.
    task automatic runOp(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                         input int stallCycles, input bit resetInExec);
        int w;
        logic [31:0] expA, expB, expR;
        logic [2:0] expC;
        applyStimulus(v0, a0, b0, c0, v1, a1, b1, c1);
        #1;
        w = expectedWinner(v0, v1);
        checkOutput("idle_req0_ready", req0_ready, (w == 0));
        checkOutput("idle_req1_ready", req1_ready, (w == 1));
        if (w < 0) begin
            @(posedge clk); #1;
            checkOutput("noreq_busy", busy, 0);
            return;
        end
        lastWinner = (w == 1);
        expA = (w == 0) ? a0 : a1;
        expB = (w == 0) ? b0 : b1;
        expC = (w == 0) ? c0 : c1;
        expR = aluRef(expA, expB, expC);

        @(posedge clk); #1;
        checkOutput("exec_busy", busy, 1);
        checkOutput("exec_alu_a", alu_a, expA);
        checkOutput("exec_alu_b", alu_b, expB);
        checkOutput("exec_alu_ctrl", alu_ctrl, expC);
        checkOutput("exec_rsp0_valid", rsp0_valid, 0);
        checkOutput("exec_rsp1_valid", rsp1_valid, 0);
        checkOutput("exec_req0_ready", req0_ready, 0);
        checkOutput("exec_req1_ready", req1_ready, 0);

        if (resetInExec) begin
            rst = 1'b1;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(posedge clk); #1;
            checkResetState();
            rst = 1'b0;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            lastWinner = 1'b1;
            @(posedge clk); #1;
            checkOutput("postrst_rsp0_valid", rsp0_valid, 0);
            checkOutput("postrst_rsp1_valid", rsp1_valid, 0);
            checkOutput("postrst_busy", busy, 0);
            return;
        end

        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        checkOutput("resp_rsp0_valid", rsp0_valid, (w == 0));
        checkOutput("resp_rsp1_valid", rsp1_valid, (w == 1));
        checkOutput("resp_result", (w == 0) ? rsp0_result : rsp1_result, expR);
        checkOutput("resp_busy", busy, 1);

        for (int i = 0; i < stallCycles; i++) begin
            rsp0_ready = (w == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rsp1_ready = (w == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checkOutput("stall_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1);
            checkOutput("stall_other_valid", (w == 0) ? rsp1_valid : rsp0_valid, 0);
            checkOutput("stall_result", (w == 0) ? rsp0_result : rsp1_result, expR);
            checkOutput("stall_req0_ready", req0_ready, 0);
            checkOutput("stall_req1_ready", req1_ready, 0);
        end

        rsp0_ready = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp1_ready = (w == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        checkOutput("done_rsp0_valid", rsp0_valid, 0);
        checkOutput("done_rsp1_valid", rsp1_valid, 0);
        checkOutput("done_busy", busy, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(1'b1, 32'h1, 32'h2, 3'b000, 1'b1, 32'h3, 32'h4, 3'b001);
        @(posedge clk); @(posedge clk); #1;
        checkResetState();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0, 3'b000);
        @(posedge clk); #1;

        $display("[TB] directed: add / sub");
        runOp(1'b1, 32'd5, 32'd3, 3'b000, 1'b0, 32'h0, 32'h0, 3'b000, 0, 1'b0);
        runOp(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'd3, 32'd5, 3'b001, 0, 1'b0);

        $display("[TB] directed: contention");
        for (int i = 0; i < 4; i++)
            runOp(1'b1, $urandom, $urandom, 3'b010, 1'b1, $urandom, $urandom, 3'b011, 0, 1'b0);

        $display("[TB] directed: backpressure, reset in EXEC, ctrl 110");
        runOp(1'b1, 32'h1234, 32'h1111, 3'b001, 1'b1, 32'h7, 32'h9, 3'b000, 10, 1'b0);
        runOp(1'b1, 32'hAA, 32'h55, 3'b011, 1'b0, 32'h0, 32'h0, 3'b000, 0, 1'b1);
        runOp(1'b1, 32'hF0F0, 32'h0FF0, 3'b110, 1'b0, 32'h0, 32'h0, 3'b000, 0, 1'b0);

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++)
            runOp(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), ($urandom_range(0, 9) == 0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
